// File: rtl/verificar_sequencia_serial_if.sv
// verificar_sequencia_serial_if
//   Bundles the control, data and status signals of the serial sequence
//   checker. The master side is the sequence generator / input front end.
//   The slave side is the checker itself.
//   Ports (master -> slave): limpar, carregar, simbolo_alvo, iniciar,
//                            entrada, entrada_valida
//   Ports (slave -> master): saida, erro, ocupado, cheio, passo, comprimento
interface verificar_sequencia_serial_if #(
    parameter int LARGURA      = 4,
    parameter int CANAIS       = 2,
    parameter int PROFUNDIDADE = 8
);
    localparam int W = $clog2(PROFUNDIDADE + 1);

    logic                       limpar;
    logic                       carregar;
    logic [CANAIS*LARGURA-1:0]  simbolo_alvo;
    logic                       iniciar;
    logic [CANAIS*LARGURA-1:0]  entrada;
    logic                       entrada_valida;
    logic                       saida;
    logic                       erro;
    logic                       ocupado;
    logic                       cheio;
    logic [W-1:0]               passo;
    logic [W-1:0]               comprimento;

    modport master (
        output limpar, carregar, simbolo_alvo, iniciar, entrada, entrada_valida,
        input  saida, erro, ocupado, cheio, passo, comprimento
    );

    modport slave (
        input  limpar, carregar, simbolo_alvo, iniciar, entrada, entrada_valida,
        output saida, erro, ocupado, cheio, passo, comprimento
    );
endinterface

// File: rtl/verificar_sequencia_serial.sv
// verificar_sequencia_serial
//   Stores a target sequence of up to PROFUNDIDADE steps. Each step holds
//   CANAIS symbols of LARGURA bits. Player entries are then checked one step
//   at a time. The result appears one cycle after each strobe.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - verificar_sequencia_serial_if.slave
//             (limpar, carregar, simbolo_alvo, iniciar, entrada,
//              entrada_valida in; saida, erro, ocupado, cheio, passo,
//              comprimento out)
//   Optional feature:
//     VERIFICAR_TIMEOUT_EN - when defined, a verification waits at most
//                            TEMPO_LIMITE cycles between entries before it
//                            fails.
module verificar_sequencia_serial #(
    parameter int LARGURA      = 4,
    parameter int CANAIS       = 2,
    parameter int PROFUNDIDADE = 8,
    parameter int TEMPO_LIMITE = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    verificar_sequencia_serial_if.slave   bus
);
    localparam int W    = $clog2(PROFUNDIDADE + 1);
    localparam int IW   = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
    localparam int SIMB = CANAIS * LARGURA;
    localparam logic [W-1:0] PROF_W = W'(PROFUNDIDADE);

    typedef enum logic [1:0] {
        OCIOSO,
        VERIFICANDO,
        ACERTO,
        ERRO
    } estado_t;

    estado_t          r_estado;
    estado_t          w_prox;
    logic [W-1:0]     r_passo;
    logic [W-1:0]     r_comp;
    logic [W-1:0]     w_passo_prox;
    logic [W-1:0]     w_comp_prox;
    logic             r_saida;
    logic             r_erro;
    logic             r_ocupado;
    logic             r_cheio;
    logic             w_escrever;
    logic             w_expirou;
    logic [SIMB-1:0]  r_mem [PROFUNDIDADE];
    logic [SIMB-1:0]  w_alvo_atual;
    logic [CANAIS-1:0] w_canal_ok;
    logic             w_igual;
    logic             w_ultimo;

    // Target memory has no reset; its contents stay valid only while
    // comprimento covers them.
    always_ff @(posedge clk) begin
        if (w_escrever) begin
            r_mem[r_comp[IW-1:0]] <= bus.simbolo_alvo;
        end
    end

    assign w_alvo_atual = r_mem[r_passo[IW-1:0]];

    always_comb begin
        w_canal_ok = '0;
        for (int unsigned k = 0; k < CANAIS; k++) begin
            w_canal_ok[k] = (bus.entrada[k*LARGURA +: LARGURA] ==
                             w_alvo_atual[k*LARGURA +: LARGURA]);
        end
    end

    assign w_igual  = &w_canal_ok;
    assign w_ultimo = (r_passo == (r_comp - 1'b1));

`ifdef VERIFICAR_TIMEOUT_EN
    localparam int CW = $clog2(TEMPO_LIMITE + 1);

    logic [CW-1:0] r_cont;
    logic [CW-1:0] w_cont_inc;

    assign w_cont_inc = r_cont + 1'b1;
    // The counter holds the number of completed waiting cycles. The limit
    // is reached on the edge that would make that number TEMPO_LIMITE.
    assign w_expirou  = (r_estado == VERIFICANDO) && (w_cont_inc == CW'(TEMPO_LIMITE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cont <= '0;
        end else if ((w_prox == VERIFICANDO) &&
                     ((r_estado != VERIFICANDO) || bus.iniciar || bus.entrada_valida)) begin
            r_cont <= '0;
        end else if (r_estado == VERIFICANDO) begin
            r_cont <= w_cont_inc;
        end
    end
`else
    assign w_expirou = 1'b0;
`endif

    always_comb begin
        w_prox       = r_estado;
        w_passo_prox = r_passo;
        w_comp_prox  = r_comp;
        w_escrever   = 1'b0;

        if (bus.limpar) begin
            w_prox       = OCIOSO;
            w_passo_prox = '0;
            w_comp_prox  = '0;
        end else if (bus.iniciar) begin
            w_passo_prox = '0;
            w_prox       = (r_comp != '0) ? VERIFICANDO : ERRO;
        end else begin
            unique case (r_estado)
                OCIOSO: begin
                    if (bus.carregar && !r_cheio) begin
                        w_escrever  = 1'b1;
                        w_comp_prox = r_comp + 1'b1;
                    end
                end
                VERIFICANDO: begin
                    // A strobe on the limit cycle is still judged on its data.
                    if (bus.entrada_valida) begin
                        if (!w_igual) begin
                            w_prox = ERRO;
                        end else if (w_ultimo) begin
                            w_prox = ACERTO;
                        end else begin
                            w_passo_prox = r_passo + 1'b1;
                        end
                    end else if (w_expirou) begin
                        w_prox = ERRO;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The flags are registered from the next state, so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado  <= OCIOSO;
            r_passo   <= '0;
            r_comp    <= '0;
            r_saida   <= 1'b0;
            r_erro    <= 1'b0;
            r_ocupado <= 1'b0;
            r_cheio   <= 1'b0;
        end else begin
            r_estado  <= w_prox;
            r_passo   <= w_passo_prox;
            r_comp    <= w_comp_prox;
            r_saida   <= (w_prox == ACERTO);
            r_erro    <= (w_prox == ERRO);
            r_ocupado <= (w_prox == VERIFICANDO);
            r_cheio   <= (w_comp_prox == PROF_W);
        end
    end

    assign bus.saida       = r_saida;
    assign bus.erro        = r_erro;
    assign bus.ocupado     = r_ocupado;
    assign bus.cheio       = r_cheio;
    assign bus.passo       = r_passo;
    assign bus.comprimento = r_comp;
endmodule

// File: tb/tb_verificar_sequencia_serial.sv
module tb_verificar_sequencia_serial;
    logic clk;
    logic rst_n;

    verificar_sequencia_serial_if #(.LARGURA(4), .CANAIS(2), .PROFUNDIDADE(8)) bus ();

    verificar_sequencia_serial #(
        .LARGURA(4),
        .CANAIS(2),
        .PROFUNDIDADE(8),
        .TEMPO_LIMITE(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lim;
        logic       car;
        logic       ini;
        logic       val;
        logic [7:0] alvo;
        logic [7:0] ent;
        logic       s;
        logic       e;
        logic       o;
        logic       c;
        logic [3:0] p;
        logic [3:0] n;
    } vec_t;

    vec_t tabela[$];
    int   nvec;
    int   nerr;

    function automatic vec_t V(input logic lim, input logic car, input logic ini,
                               input logic val, input logic [7:0] alvo,
                               input logic [7:0] ent, input logic s, input logic e,
                               input logic o, input logic c, input logic [3:0] p,
                               input logic [3:0] n);
        vec_t r;
        r.lim = lim; r.car = car; r.ini = ini; r.val = val;
        r.alvo = alvo; r.ent = ent;
        r.s = s; r.e = e; r.o = o; r.c = c; r.p = p; r.n = n;
        return r;
    endfunction

    task automatic verificar(input string nome, input logic s, input logic e,
                             input logic o, input logic c, input logic [3:0] p,
                             input logic [3:0] n);
        logic [11:0] got;
        logic [11:0] expv;
        got  = {bus.saida, bus.erro, bus.ocupado, bus.cheio, bus.passo, bus.comprimento};
        expv = {s, e, o, c, p, n};
        nvec++;
        if (got !== expv) begin
            nerr++;
            $display("FAIL %s: got saida=%b erro=%b ocupado=%b cheio=%b passo=%0d comprimento=%0d, expected saida=%b erro=%b ocupado=%b cheio=%b passo=%0d comprimento=%0d",
                     nome, got[11], got[10], got[9], got[8], got[7:4], got[3:0],
                     s, e, o, c, p, n);
        end
    endtask

    task automatic aplicar(input vec_t v, input string nome);
        @(negedge clk);
        bus.limpar         = v.lim;
        bus.carregar       = v.car;
        bus.iniciar        = v.ini;
        bus.entrada_valida = v.val;
        bus.simbolo_alvo   = v.alvo;
        bus.entrada        = v.ent;
        @(posedge clk);
        #1;
        verificar(nome, v.s, v.e, v.o, v.c, v.p, v.n);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        bus.limpar = 0; bus.carregar = 0; bus.iniciar = 0; bus.entrada_valida = 0;
        bus.simbolo_alvo = '0; bus.entrada = '0;
        rst_n = 1'b0;

        //            lim car ini val alvo   ent    s  e  o  c  p  n
        tabela.push_back(V(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // idle after reset
        tabela.push_back(V(0, 1, 0, 0, 8'h12, 8'h00, 0, 0, 0, 0, 0, 1));
        tabela.push_back(V(0, 1, 0, 0, 8'h34, 8'h00, 0, 0, 0, 0, 0, 2));
        tabela.push_back(V(0, 1, 0, 0, 8'h56, 8'h00, 0, 0, 0, 0, 0, 3));
        tabela.push_back(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 3));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h12, 0, 0, 1, 0, 1, 3));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h34, 0, 0, 1, 0, 2, 3));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h56, 1, 0, 0, 0, 2, 3)); // success
        tabela.push_back(V(0, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 2, 3)); // ACERTO holds
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, 0, 0, 2, 3)); // strobe ignored
        tabela.push_back(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 3));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h12, 0, 0, 1, 0, 1, 3));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h35, 0, 1, 0, 0, 1, 3)); // ch0 mismatch
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h56, 0, 1, 0, 0, 1, 3)); // ignored in ERRO
        tabela.push_back(V(0, 1, 0, 0, 8'h77, 8'h00, 0, 1, 0, 0, 1, 3)); // load ignored
        tabela.push_back(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 3));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h12, 0, 0, 1, 0, 1, 3));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h34, 0, 0, 1, 0, 2, 3));
        tabela.push_back(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 3)); // restart at 2
        tabela.push_back(V(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // limpar
        tabela.push_back(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0)); // empty -> ERRO
        tabela.push_back(V(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // ERRO -> OCIOSO
        for (int i = 1; i <= 8; i++) begin
            tabela.push_back(V(0, 1, 0, 0, 8'(i), 8'h00, 0, 0, 0, (i == 8), 0, 4'(i)));
        end
        tabela.push_back(V(0, 1, 0, 0, 8'h09, 8'h00, 0, 0, 0, 1, 0, 8)); // full: ignored
        tabela.push_back(V(0, 1, 1, 0, 8'hAA, 8'h00, 0, 0, 1, 1, 0, 8)); // iniciar wins
        for (int i = 1; i <= 7; i++) begin
            tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'(i), 0, 0, 1, 1, 4'(i), 8));
        end
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'h08, 1, 0, 0, 1, 7, 8)); // last step
        tabela.push_back(V(1, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0)); // limpar wins
        tabela.push_back(V(0, 1, 0, 0, 8'hAB, 8'h00, 0, 0, 0, 0, 0, 1));
        tabela.push_back(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 1));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'hBB, 0, 1, 0, 0, 0, 1)); // ch1 mismatch
        tabela.push_back(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 1));
        tabela.push_back(V(0, 0, 0, 1, 8'h00, 8'hAB, 1, 0, 0, 0, 0, 1)); // 1-step success

        #12;
        rst_n = 1'b1;
        verificar("reset", 0, 0, 0, 0, 0, 0);

        foreach (tabela[i]) begin
            aplicar(tabela[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset in the middle of the low clock phase.
        @(negedge clk);
        bus.entrada_valida = 0; bus.carregar = 0; bus.iniciar = 0; bus.limpar = 0;
        #2;
        rst_n = 1'b0;
        #1;
        verificar("async_reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        aplicar(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 1, 0, 0, 0, 0), "reset_loses_seq");

`ifdef VERIFICAR_TIMEOUT_EN
        aplicar(V(1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), "to_clear");
        aplicar(V(0, 1, 0, 0, 8'h12, 8'h00, 0, 0, 0, 0, 0, 1), "to_load0");
        aplicar(V(0, 1, 0, 0, 8'h34, 8'h00, 0, 0, 0, 0, 0, 2), "to_load1");
        aplicar(V(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 2), "to_start");
        for (int i = 0; i < 8; i++) begin
            aplicar(V(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 2), "to_wait_a");
        end
        aplicar(V(0, 0, 0, 1, 8'h00, 8'h12, 0, 0, 1, 0, 1, 2), "to_strobe9");
        for (int i = 0; i < 9; i++) begin
            aplicar(V(0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 1, 2), "to_wait_b");
        end
        aplicar(V(0, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 1, 2), "to_expired");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/verificar_sequencia_serial.md
Name: verificar_sequencia_serial

Overview:
- Sequential, parametrised checker for the sequence-entry game.
- Stores a target sequence of up to PROFUNDIDADE steps, each step holding one LARGURA-bit symbol per channel.
- Compares player input one step at a time and reports success or failure.
- Sits between the sequence generator, which loads targets, and the input/debounce front end, which supplies entries; drives the game-result logic.

Parameters:
LARGURA, 4, bits per symbol per channel
CANAIS, 2, number of channels compared in parallel; a step matches only if all channels match
PROFUNDIDADE, 8, maximum sequence length in steps (>=1)
TEMPO_LIMITE, 1000, clock cycles allowed between entries (used only with VERIFICAR_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
limpar  in  1  clears loaded length to 0; returns to OCIOSO
carregar  in  1  write simbolo_alvo at position comprimento (OCIOSO only)
simbolo_alvo  in  CANAIS*LARGURA  target step; channel k in bits [k*LARGURA +: LARGURA]
iniciar  in  1  start/restart verification at step 0
entrada  in  CANAIS*LARGURA  player step, same packing as simbolo_alvo
entrada_valida  in  1  one-cycle strobe; entrada is sampled on this edge
saida  out  1  high while in ACERTO
erro  out  1  high while in ERRO
ocupado  out  1  high while in VERIFICANDO
cheio  out  1  comprimento == PROFUNDIDADE
passo  out  clog2(PROFUNDIDADE+1)  index of the next expected step
comprimento  out  clog2(PROFUNDIDADE+1)  number of steps loaded

Behaviour:
- Reset (asynchronous, rst_n low): state OCIOSO; saida, erro, ocupado, cheio, passo and comprimento all 0. Target memory contents are not reset.
- All outputs are registered and change only on the rising edge of clk, or asynchronously on reset.
- States:
  - OCIOSO -> VERIFICANDO on iniciar when comprimento>0.
  - OCIOSO -> ERRO on iniciar when comprimento==0.
  - VERIFICANDO -> ACERTO on entrada_valida with a full match and passo==comprimento-1.
  - VERIFICANDO stays in VERIFICANDO on a full match otherwise; passo increments.
  - VERIFICANDO -> ERRO on entrada_valida with any channel mismatch.
  - ACERTO and ERRO hold until iniciar (-> VERIFICANDO with passo=0, or -> ERRO if comprimento==0) or limpar (-> OCIOSO).
- Load: in OCIOSO, carregar with !cheio writes memory[comprimento] and increments comprimento. carregar while cheio is ignored. carregar outside OCIOSO is ignored.
- Compare: entrada is compared against memory[passo], all CANAIS fields bitwise. Result is visible the cycle after the strobe edge, so latency is 1 cycle.
- Priority, highest first: limpar > iniciar > carregar / entrada_valida.
  - limpar sets comprimento=0 and passo=0, state OCIOSO.
  - iniciar in any state sets passo=0. iniciar during VERIFICANDO restarts at step 0.
  - carregar and iniciar together in OCIOSO: iniciar taken, carregar dropped.
- entrada_valida outside VERIFICANDO is ignored.
- passo holds its value in ACERTO and ERRO. In ERRO it identifies the failing step.
- Reset mid-operation: immediate return to reset values; the loaded sequence is lost because comprimento=0.

Optional Feature:
- Macro: VERIFICAR_TIMEOUT_EN.
- When defined:
  - A counter clears on entering VERIFICANDO and on every entrada_valida.
  - It increments each cycle in VERIFICANDO.
  - When it reaches TEMPO_LIMITE with no strobe that cycle, state -> ERRO and passo holds.
  - A strobe on the same cycle takes precedence.
  - The counter is sized clog2(TEMPO_LIMITE+1).
- When undefined: no counter logic; VERIFICANDO waits indefinitely.

Test Plan:
- Config CANAIS=2, LARGURA=4, PROFUNDIDADE=8 unless stated.
- Reset: pulse rst_n low mid-cycle -> all outputs 0 immediately, with no clock edge needed.
- Load 3 steps 0x12, 0x34, 0x56; iniciar; enter 0x12, 0x34, 0x56 -> ocupado for 3 cycles, saida=1 one cycle after the third strobe, passo=2, erro=0.
- Same load; enter 0x12, then 0x35 (channel 0 off by one bit) -> erro=1 after the second strobe, passo=1, saida=0; further strobes are ignored.
- Load 9 steps -> comprimento=8, cheio=1 after the 8th; the 9th is ignored. carregar together with iniciar in OCIOSO -> no write, state VERIFICANDO.
- iniciar with comprimento=0 -> erro=1. limpar from ERRO -> OCIOSO, all flags 0. iniciar during VERIFICANDO at passo=2 -> passo=0, ocupado stays 1.
- With VERIFICAR_TIMEOUT_EN and TEMPO_LIMITE=10: iniciar, no strobes -> erro=1 after cycle 10 in VERIFICANDO; a strobe arriving on cycle 9 restarts the count.
